// File: rtl/alu_issue_decoder.sv
// RV32I issue-stage decoder: turns one instruction plus its register operands into
// an ALU control code and operand pair, registered behind a valid/ready skid buffer.
module alu_issue_decoder #(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_ctrl,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_branch,
  output logic            out_br_invert,
  output logic            out_illegal
);

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLT   = 4'b0101,
    ALU_SLTU  = 4'b0110,
    ALU_AUIPC = 4'b1000,
    ALU_LUI   = 4'b1001,
    ALU_SLL   = 4'b1010,
    ALU_SRA   = 4'b1011,
    ALU_SRL   = 4'b1100
  } alu_op_e;

  typedef struct packed {
    alu_op_e         alu_ctrl;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic            we;
    logic            branch;
    logic            br_invert;
    logic            illegal;
  } bundle_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] shamt_rs2, shamt_imm;
  logic            legal, writes_rd;
  bundle_t         dec;

  assign opcode    = in_instr[6:0];
  assign funct3    = in_instr[14:12];
  assign funct7    = in_instr[31:25];
  assign imm_i     = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s     = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b     = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25],
                      in_instr[11:8], 1'b0};
  assign imm_u     = {in_instr[31:12], 12'h000};
  assign imm_j     = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20],
                      in_instr[30:21], 1'b0};
  assign shamt_rs2 = {{(XLEN-5){1'b0}}, in_rs2_data[4:0]};
  assign shamt_imm = {{(XLEN-5){1'b0}}, in_instr[24:20]};

  // NOTE: combinational blocks use blocking '=' and give every output a default
  // first, so later branches override cleanly and no latch can be inferred.
  always_comb begin
    dec       = '0;
    legal     = 1'b1;
    writes_rd = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.a     = in_rs1_data;
        dec.b     = in_rs2_data;
        writes_rd = 1'b1;
        if (funct7 == F7_ZERO) begin
          case (funct3)
            3'b000:  dec.alu_ctrl = ALU_ADD;
            3'b001:  begin dec.alu_ctrl = ALU_SLL; dec.b = shamt_rs2; end
            3'b010:  dec.alu_ctrl = ALU_SLT;
            3'b011:  dec.alu_ctrl = ALU_SLTU;
            3'b100:  dec.alu_ctrl = ALU_XOR;
            3'b101:  begin dec.alu_ctrl = ALU_SRL; dec.b = shamt_rs2; end
            3'b110:  dec.alu_ctrl = ALU_OR;
            default: dec.alu_ctrl = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec.alu_ctrl = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec.alu_ctrl = ALU_SRA;
          dec.b        = shamt_rs2;
        end else begin
          legal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        dec.a     = in_rs1_data;
        dec.b     = imm_i;
        dec.imm   = imm_i;
        writes_rd = 1'b1;
        case (funct3)
          3'b000: dec.alu_ctrl = ALU_ADD;
          3'b010: dec.alu_ctrl = ALU_SLT;
          3'b011: dec.alu_ctrl = ALU_SLTU;
          3'b100: dec.alu_ctrl = ALU_XOR;
          3'b110: dec.alu_ctrl = ALU_OR;
          3'b111: dec.alu_ctrl = ALU_AND;
          3'b001: begin
            dec.alu_ctrl = ALU_SLL;
            dec.b        = shamt_imm;
            legal        = (funct7 == F7_ZERO);
          end
          default: begin
            dec.alu_ctrl = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            dec.b        = shamt_imm;
            legal        = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
          end
        endcase
      end
      OPC_LUI: begin
        dec.alu_ctrl = ALU_LUI;
        dec.b        = imm_u;
        dec.imm      = imm_u;
        writes_rd    = 1'b1;
      end
      OPC_AUIPC: begin
        dec.alu_ctrl = ALU_AUIPC;
        dec.a        = in_pc;
        dec.b        = imm_u;
        dec.imm      = imm_u;
        writes_rd    = 1'b1;
      end
      OPC_LOAD: begin
        dec.a     = in_rs1_data;
        dec.b     = imm_i;
        dec.imm   = imm_i;
        writes_rd = 1'b1;
      end
      OPC_STORE: begin
        dec.a   = in_rs1_data;
        dec.b   = imm_s;
        dec.imm = imm_s;
      end
      OPC_JAL, OPC_JALR: begin
        // The ALU forms the link value pc+4; the jump target leaves via out_imm.
        dec.a     = in_pc;
        dec.b     = XLEN'(4);
        dec.imm   = (opcode == OPC_JAL) ? imm_j : imm_i;
        writes_rd = 1'b1;
      end
      OPC_BRANCH: begin
        dec.a      = in_rs1_data;
        dec.b      = in_rs2_data;
        dec.imm    = imm_b;
        dec.branch = 1'b1;
        case (funct3)
          3'b000:  dec.alu_ctrl = ALU_SUB;
          3'b001:  begin dec.alu_ctrl = ALU_SUB;  dec.br_invert = 1'b1; end
          3'b100:  begin dec.alu_ctrl = ALU_SLT;  dec.br_invert = 1'b1; end
          3'b101:  dec.alu_ctrl = ALU_SLT;
          3'b110:  begin dec.alu_ctrl = ALU_SLTU; dec.br_invert = 1'b1; end
          3'b111:  dec.alu_ctrl = ALU_SLTU;
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    if (writes_rd) begin
      dec.rd = in_instr[11:7];
      dec.we = (in_instr[11:7] != 5'd0);
    end
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  bundle_t out_q, out_d, skid_q, skid_d;
  logic    out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic    in_ready_q, in_ready_d;
  logic    accept, out_free;

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = SKID_EN ? (in_ready_q && !reset) : (out_free && !reset);
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) out_d = dec;
      end
    end else if (accept && SKID_EN) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  // NOTE: the skid payload is qualified by skid_valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  assign out_valid     = out_valid_q;
  assign out_alu_ctrl  = out_q.alu_ctrl;
  assign out_a         = out_q.a;
  assign out_b         = out_q.b;
  assign out_imm       = out_q.imm;
  assign out_rd        = out_q.rd;
  assign out_we        = out_q.we;
  assign out_branch    = out_q.branch;
  assign out_br_invert = out_q.br_invert;
  assign out_illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Bench for alu_issue_decoder: directed decode/handshake cases, then random traffic
// checked against a mnemonic-level reference model and an in-order expectation queue.
module tb_alu_issue_decoder;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data;
  logic [3:0]  out_alu_ctrl;
  logic [31:0] out_a, out_b, out_imm;
  logic [4:0]  out_rd;
  logic        out_we, out_branch, out_br_invert, out_illegal;

  always #5 clk = ~clk;

  alu_issue_decoder #(.XLEN(32), .SKID_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_ctrl(out_alu_ctrl),
    .out_a(out_a), .out_b(out_b), .out_imm(out_imm), .out_rd(out_rd), .out_we(out_we),
    .out_branch(out_branch), .out_br_invert(out_br_invert), .out_illegal(out_illegal)
  );

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a, b, imm;
    logic [4:0]  rd;
    logic        we, br, inv, ill;
  } exp_t;

  exp_t q[$];
  int   delivered_rd[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   rst_prev = 1'b0;

  localparam logic [31:0] I1 = 32'h00100093;  // addi x1,x0,1
  localparam logic [31:0] I2 = 32'h00200113;  // addi x2,x0,2
  localparam logic [31:0] I3 = 32'h00300193;  // addi x3,x0,3
  localparam logic [31:0] I7 = 32'h00700393;  // addi x7,x0,7

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic string rname(input logic [2:0] f3);
    case (f3)
      3'd0: return "add";  3'd1: return "sll";  3'd2: return "slt";  3'd3: return "sltu";
      3'd4: return "xor";  3'd5: return "srl";  3'd6: return "or";   default: return "and";
    endcase
  endfunction

  function automatic string bname(input logic [2:0] f3);
    case (f3)
      3'd0: return "beq";  3'd1: return "bne";  3'd4: return "blt";  3'd5: return "bge";
      3'd6: return "bltu"; 3'd7: return "bgeu"; default: return "";
    endcase
  endfunction

  function automatic logic [3:0] code_of(input string m);
    case (m)
      "add": return 4'h0;  "sub", "beq", "bne": return 4'h1;  "and": return 4'h2;
      "or": return 4'h3;   "xor": return 4'h4;  "slt", "blt", "bge": return 4'h5;
      "sltu", "bltu", "bgeu": return 4'h6;  "auipc": return 4'h8;  "lui": return 4'h9;
      "sll": return 4'hA;  "sra": return 4'hB;  "srl": return 4'hC;
      default: return 4'hF;
    endcase
  endfunction

  // Name the instruction first, then derive operands and codes from the mnemonic.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] x1, input logic [31:0] x2);
    exp_t e;
    string m;
    bit wr;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [31:0] ii, is_, ib, iu, ij;
    f7  = ins[31:25];
    f3  = ins[14:12];
    ii  = $signed(ins) >>> 20;
    is_ = {ii[31:5], ins[11:7]};
    ib  = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    iu  = ins & 32'hFFFFF000;
    ij  = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    e.ctrl = 4'h0; e.a = 0; e.b = 0; e.imm = 0; e.rd = 0;
    e.we = 0; e.br = 0; e.inv = 0; e.ill = 0;
    wr = 0;
    m  = "";
    case (ins[6:0])
      7'h33: begin
        if (f7 == 7'h00) m = rname(f3);
        else if (f7 == 7'h20 && f3 == 3'd0) m = "sub";
        else if (f7 == 7'h20 && f3 == 3'd5) m = "sra";
        e.a = x1; e.b = x2; wr = 1;
      end
      7'h13: begin
        m = rname(f3);
        if (f3 == 3'd1 && f7 != 7'h00) m = "";
        if (f3 == 3'd5) m = (f7 == 7'h00) ? "srl" : (f7 == 7'h20) ? "sra" : "";
        e.a = x1; e.b = ii; e.imm = ii; wr = 1;
      end
      7'h37: begin m = "lui";   e.a = 0;  e.b = iu;  e.imm = iu;  wr = 1; end
      7'h17: begin m = "auipc"; e.a = pc; e.b = iu;  e.imm = iu;  wr = 1; end
      7'h03: begin m = "add";   e.a = x1; e.b = ii;  e.imm = ii;  wr = 1; end
      7'h23: begin m = "add";   e.a = x1; e.b = is_; e.imm = is_; end
      7'h6F: begin m = "add";   e.a = pc; e.b = 4;   e.imm = ij;  wr = 1; end
      7'h67: begin m = "add";   e.a = pc; e.b = 4;   e.imm = ii;  wr = 1; end
      7'h63: begin m = bname(f3); e.a = x1; e.b = x2; e.imm = ib; e.br = 1; end
      default: m = "";
    endcase
    if (m == "") begin
      e.a = 0; e.b = 0; e.imm = 0; e.br = 0; e.ill = 1;
      return e;
    end
    if (m == "sll" || m == "srl" || m == "sra") e.b = e.b % 32;
    e.inv  = (m == "bne" || m == "blt" || m == "bltu");
    e.ctrl = code_of(m);
    e.rd   = wr ? ins[11:7] : 5'd0;
    e.we   = wr && (ins[11:7] != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  ops[9];
    int k;
    ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h6F, 7'h67, 7'h63};
    ins = $urandom;
    k   = $urandom_range(0, 9);
    if (k < 9) ins[6:0] = ops[k];
    if ($urandom_range(0, 3) != 0) ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    return ins;
  endfunction

  // One clock: check DUT against the model at the falling edge, then advance the model.
  task automatic step();
    logic exp_rdy;
    @(negedge clk);
    exp_rdy = !reset && (q.size() < 2);
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, q.size() > 0);
    if (rst_prev) begin
      check("rst_ctrl", out_alu_ctrl, 0);
      check("rst_a", out_a, 0);
      check("rst_b", out_b, 0);
      check("rst_imm", out_imm, 0);
      check("rst_rd", out_rd, 0);
      check("rst_flags", {out_we, out_branch, out_br_invert, out_illegal}, 0);
    end
    if (q.size() > 0) begin
      check("ctrl", out_alu_ctrl, q[0].ctrl);
      check("a", out_a, q[0].a);
      check("b", out_b, q[0].b);
      check("imm", out_imm, q[0].imm);
      check("rd", out_rd, q[0].rd);
      check("flags", {out_we, out_branch, out_br_invert, out_illegal},
            {q[0].we, q[0].br, q[0].inv, q[0].ill});
    end
    if (out_valid && out_ready && !reset) delivered_rd.push_back(int'(out_rd));
    if (reset) q.delete();
    else begin
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (flush) q.delete();
      else if (in_valid && exp_rdy) q.push_back(ref_decode(in_instr, in_pc, in_rs1_data, in_rs2_data));
    end
    rst_prev = reset;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    in_instr = ins; in_pc = 32'h0000_1000; in_rs1_data = r1; in_rs2_data = r2;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = 0; in_pc = 0; in_rs1_data = 0; in_rs2_data = 0;
    repeat (3) step();
    check("reset_in_ready", in_ready, 0);
    reset = 1'b0;
    step();
    check("ready_after_reset", in_ready, 1);

    send(32'h002081B3, 5, 7);  // add x3,x1,x2
    check("add_ctrl", out_alu_ctrl, 4'b0000);
    check("add_a", out_a, 5);
    check("add_b", out_b, 7);
    check("add_rd", out_rd, 3);
    check("add_we", out_we, 1);
    check("add_ill", out_illegal, 0);

    send(32'h40335293, 32'hF000_0000, 32'hFFFF_FFFF);  // srai x5,x6,3
    check("srai_ctrl", out_alu_ctrl, 4'b1011);
    check("srai_b", out_b, 3);
    check("srai_rd", out_rd, 5);

    send(32'h123450B7, 32'h55, 32'h66);  // lui x1,0x12345
    check("lui_ctrl", out_alu_ctrl, 4'b1001);
    check("lui_a", out_a, 0);
    check("lui_b", out_b, 32'h12345000);

    send(32'h0020D463, 9, 4);  // bge x1,x2,+8
    check("bge_ctrl", out_alu_ctrl, 4'b0101);
    check("bge_branch", out_branch, 1);
    check("bge_inv", out_br_invert, 0);
    check("bge_we", out_we, 0);
    check("bge_imm", out_imm, 8);

    send(32'h02208133, 11, 22);  // mul x2,x1,x2
    check("mul_ill", out_illegal, 1);
    check("mul_we", out_we, 0);
    check("mul_ctrl", out_alu_ctrl, 0);
    check("mul_a", out_a, 0);
    check("mul_b", out_b, 0);

    send(32'h00208033, 1, 2);  // add x0,x1,x2
    check("rd0_we", out_we, 0);
    step();

    // Backpressure: two accepted, third refused until the stall clears.
    delivered_rd.delete();
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = I1; step();
    in_instr = I2; step();
    in_instr = I3;
    check("bp_in_ready_low", in_ready, 0);
    repeat (3) begin
      step();
      check("bp_stall_b", out_b, 1);
      check("bp_stall_rd", out_rd, 1);
    end
    out_ready = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    repeat (3) step();
    check("bp_count", delivered_rd.size(), 3);
    for (int i = 0; i < 3; i++)
      check("bp_order", (i < delivered_rd.size()) ? delivered_rd[i] : -1, i + 1);

    // Flush with both entries full, and flush with an empty buffer and a live offer.
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = I1; step();
    in_instr = I2; step();
    in_instr = I7; flush = 1'b1; step();
    check("flush_full_valid", out_valid, 0);
    flush = 1'b1; step();
    check("flush_empty_valid", out_valid, 0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    delivered_rd.delete();
    repeat (4) step();
    check("flush_no_emit", delivered_rd.size(), 0);

    // Reset in the middle of traffic.
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = I1; step();
    in_instr = I2; step();
    reset = 1'b1; step();
    check("midrst_valid", out_valid, 0);
    check("midrst_imm", out_imm, 0);
    check("midrst_rd", out_rd, 0);
    check("midrst_ready", in_ready, 0);
    reset = 1'b0; in_valid = 1'b0;
    step();
    check("midrst_ready_after", in_ready, 1);

    // Random traffic against the model.
    repeat (600) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 40) == 0);
      in_instr    = rand_instr();
      in_pc       = $urandom & 32'hFFFF_FFFC;
      in_rs1_data = $urandom;
      in_rs2_data = $urandom;
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
